// File: rtl/i2c_target_regfile.sv
// Oversampled I2C target that maps bus transactions onto an external byte register file.
// A pointer byte selects the register; data writes and reads auto-increment the pointer.

module i2c_target_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt
);
    localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
    localparam logic [CW-1:0] RELOAD = CW'(FILTER_LEN - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Down-counter reloads whenever the synchronised input agrees with the filtered value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b11;
            filt <= 1'b1;
            cnt  <= RELOAD;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == filt) begin
                cnt <= RELOAD;
            end else if (cnt == '0) begin
                filt <= sync[1];
                cnt  <= RELOAD;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end
endmodule

// state     | meaning
// IDLE      | bus free, waiting for START
// ADDR      | shifting in the address byte
// ADDR_ACK  | driving ACK for a matched address
// PTR       | shifting in the pointer byte
// PTR_ACK   | driving ACK for a valid pointer
// WDATA     | shifting in a data byte to write
// WDATA_ACK | driving ACK for a written byte
// RDATA     | shifting out the byte at rd_addr
// RDATA_ACK | sampling the controller's ACK/NACK
// IGNORE    | not addressed, waiting for START/STOP
module i2c_target_regfile #(
    parameter logic [6:0] ADDRESS    = 7'h42,
    parameter int         NUM_REGS   = 8,
    parameter int         FILTER_LEN = 3,
    localparam int        PW         = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    output logic          wr_en,
    output logic [PW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic [PW-1:0] rd_addr,
    input  logic [7:0]    rd_data,
    output logic          busy,
    output logic [PW-1:0] ptr
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    localparam logic [8:0] NREGS = 9'(NUM_REGS);

    state_t     state;
    logic [3:0] bit_cnt;
    logic [7:0] sr;
    logic       rw;
    logic       ack_rx;
    logic       scl_f, sda_f, scl_d, sda_d;
    logic       scl_rise, scl_fall, start_det, stop_det;

    i2c_target_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk(clk), .rst(rst), .raw(scl_i), .filt(scl_f)
    );
    i2c_target_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk(clk), .rst(rst), .raw(sda_i), .filt(sda_f)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_f;
            sda_d <= sda_f;
        end
    end

    assign scl_rise  = scl_f & ~scl_d;
    assign scl_fall  = ~scl_f & scl_d;
    assign start_det = ~sda_f & sda_d & scl_f;
    assign stop_det  = sda_f & ~sda_d & scl_f;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(NUM_REGS - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            sr      <= '0;
            rw      <= 1'b0;
            ack_rx  <= 1'b0;
            sda_oe  <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            rd_addr <= '0;
            busy    <= 1'b0;
            ptr     <= '0;
        end else begin
            wr_en <= 1'b0;
            if (start_det) begin
                state   <= ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else if (stop_det) begin
                state   <= IDLE;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            sr      <= {sr[6:0], sda_f};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            if (sr[7:1] == ADDRESS) begin
                                sda_oe <= 1'b1;
                                busy   <= 1'b1;
                                rw     <= sr[0];
                                state  <= ADDR_ACK;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    PTR: begin
                        if (scl_rise) begin
                            sr      <= {sr[6:0], sda_f};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            if ({1'b0, sr} < NREGS) begin
                                ptr     <= sr[PW-1:0];
                                rd_addr <= sr[PW-1:0];
                                sda_oe  <= 1'b1;
                                state   <= PTR_ACK;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    WDATA: begin
                        if (scl_rise) begin
                            sr      <= {sr[6:0], sda_f};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                wr_en   <= 1'b1;
                                wr_addr <= ptr;
                                wr_data <= {sr[6:0], sda_f};
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            sda_oe  <= 1'b1;
                            state   <= WDATA_ACK;
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw) begin
                                sr      <= rd_data;
                                sda_oe  <= ~rd_data[7];
                                bit_cnt <= '0;
                                state   <= RDATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= PTR;
                            end
                        end
                    end
                    PTR_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            state  <= WDATA;
                        end
                    end
                    WDATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            ptr     <= ptr_inc(ptr);
                            rd_addr <= ptr_inc(ptr);
                            state   <= WDATA;
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                bit_cnt <= '0;
                                sda_oe  <= 1'b0;
                                state   <= RDATA_ACK;
                            end else begin
                                sda_oe <= ~sr[6];
                                sr     <= {sr[6:0], 1'b0};
                            end
                        end
                    end
                    RDATA_ACK: begin
                        // Advance on the ACK rise so rd_data has settled before the next load.
                        if (scl_rise) begin
                            ack_rx  <= ~sda_f;
                            ptr     <= ptr_inc(ptr);
                            rd_addr <= ptr_inc(ptr);
                        end else if (scl_fall) begin
                            if (ack_rx) begin
                                sr      <= rd_data;
                                sda_oe  <= ~rd_data[7];
                                bit_cnt <= '0;
                                state   <= RDATA;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile: bit-banged controller on a wired-AND SDA,
// fixed read table on rd_data, write strobes captured into queues.

module tb_i2c_target_regfile;
    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_i = 1'b1;
    logic       sda_drv = 1'b1;
    logic       sda_i;
    logic       sda_oe;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
    logic [2:0] ptr;

    int n_cmp = 0;
    int n_bad = 0;

    logic [2:0] wq_a[$];
    logic [7:0] wq_d[$];
    logic       oe_seen = 1'b0;
    logic       busy_seen = 1'b0;

    i2c_target_regfile dut (
        .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
        .rd_data(rd_data), .busy(busy), .ptr(ptr)
    );

    always #5 clk = ~clk;

    assign sda_i = sda_drv & ~sda_oe;

    always_comb begin
        case (rd_addr)
            3'd1:    rd_data = 8'h3C;
            3'd2:    rd_data = 8'hC3;
            default: rd_data = 8'hE7;
        endcase
    end

    always @(negedge clk) begin
        if (wr_en) begin
            wq_a.push_back(wr_addr);
            wq_d.push_back(wr_data);
        end
        if (sda_oe) oe_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic clr_mon();
        wq_a.delete();
        wq_d.delete();
        oe_seen = 1'b0;
        busy_seen = 1'b0;
    endtask

    task automatic bus_bit(input logic b, input logic glitch, output logic s);
        repeat (Q) @(negedge clk);
        sda_drv = b;
        if (glitch) begin
            repeat (3) @(negedge clk);
            scl_i = 1'b1;
            @(negedge clk);
            scl_i = 1'b0;
            repeat (Q - 4) @(negedge clk);
        end else begin
            repeat (Q) @(negedge clk);
        end
        scl_i = 1'b1;
        repeat (Q) @(negedge clk);
        s = sda_i;
        repeat (Q) @(negedge clk);
        scl_i = 1'b0;
    endtask

    task automatic start_c();
        repeat (Q) @(negedge clk);
        sda_drv = 1'b1;
        repeat (Q) @(negedge clk);
        scl_i = 1'b1;
        repeat (Q) @(negedge clk);
        sda_drv = 1'b0;
        repeat (Q) @(negedge clk);
        scl_i = 1'b0;
    endtask

    task automatic stop_c();
        repeat (Q) @(negedge clk);
        sda_drv = 1'b0;
        repeat (Q) @(negedge clk);
        scl_i = 1'b1;
        repeat (Q) @(negedge clk);
        sda_drv = 1'b1;
        repeat (Q) @(negedge clk);
    endtask

    task automatic wr_byte(input logic [7:0] b, input int gbit, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], i == gbit, s);
        bus_bit(1'b1, 1'b0, s);
        ack = ~s;
    endtask

    task automatic rd_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, 1'b0, s);
            d[i] = s;
        end
        bus_bit(~mack, 1'b0, s);
    endtask

    initial begin
        logic       a0, a1, a2, a3;
        logic [7:0] d0, d1;

        repeat (3) @(negedge clk);
        check_val("rst_sda_oe", sda_oe, 0);
        check_val("rst_wr_en", wr_en, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_ptr", ptr, 0);
        check_val("rst_wr_addr", wr_addr, 0);
        check_val("rst_wr_data", wr_data, 0);
        check_val("rst_rd_addr", rd_addr, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Pointer 2, two data bytes
        clr_mon();
        start_c();
        wr_byte(8'h84, -1, a0);
        wr_byte(8'h02, -1, a1);
        wr_byte(8'hAA, -1, a2);
        wr_byte(8'h55, -1, a3);
        check_val("t1_busy_mid", busy, 1);
        stop_c();
        check_val("t1_ack_addr", a0, 1);
        check_val("t1_ack_ptr", a1, 1);
        check_val("t1_ack_d0", a2, 1);
        check_val("t1_ack_d1", a3, 1);
        check_val("t1_nwr", wq_a.size(), 2);
        check_val("t1_wr0_addr", wq_a[0], 2);
        check_val("t1_wr0_data", wq_d[0], 8'hAA);
        check_val("t1_wr1_addr", wq_a[1], 3);
        check_val("t1_wr1_data", wq_d[1], 8'h55);
        check_val("t1_ptr", ptr, 4);
        check_val("t1_busy_end", busy, 0);

        // Pointer wrap 7 -> 0
        clr_mon();
        start_c();
        wr_byte(8'h84, -1, a0);
        wr_byte(8'h07, -1, a1);
        wr_byte(8'h11, -1, a2);
        wr_byte(8'h22, -1, a3);
        stop_c();
        check_val("t2_nwr", wq_a.size(), 2);
        check_val("t2_wr0_addr", wq_a[0], 7);
        check_val("t2_wr0_data", wq_d[0], 8'h11);
        check_val("t2_wr1_addr", wq_a[1], 0);
        check_val("t2_wr1_data", wq_d[1], 8'h22);
        check_val("t2_ptr", ptr, 1);

        // Pointer set, repeated START, two reads
        clr_mon();
        start_c();
        wr_byte(8'h84, -1, a0);
        wr_byte(8'h01, -1, a1);
        start_c();
        wr_byte(8'h85, -1, a2);
        rd_byte(1'b1, d0);
        rd_byte(1'b0, d1);
        repeat (Q) @(negedge clk);
        check_val("t3_oe_after_nack", sda_oe, 0);
        stop_c();
        check_val("t3_ack_raddr", a2, 1);
        check_val("t3_rd0", d0, 8'h3C);
        check_val("t3_rd1", d1, 8'hC3);
        check_val("t3_ptr", ptr, 3);
        check_val("t3_nwr", wq_a.size(), 0);

        // Foreign address
        clr_mon();
        start_c();
        wr_byte(8'h90, -1, a0);
        wr_byte(8'h00, -1, a1);
        stop_c();
        check_val("t4_ack_addr", a0, 0);
        check_val("t4_oe_seen", oe_seen, 0);
        check_val("t4_busy_seen", busy_seen, 0);
        check_val("t4_nwr", wq_a.size(), 0);

        // Out-of-range pointer
        clr_mon();
        start_c();
        wr_byte(8'h84, -1, a0);
        wr_byte(8'h09, -1, a1);
        wr_byte(8'h33, -1, a2);
        stop_c();
        check_val("t5_ack_addr", a0, 1);
        check_val("t5_ack_ptr", a1, 0);
        check_val("t5_ack_data", a2, 0);
        check_val("t5_ptr", ptr, 3);
        check_val("t5_nwr", wq_a.size(), 0);

        // 1-clk SCL glitch inside a data bit
        clr_mon();
        start_c();
        wr_byte(8'h84, -1, a0);
        wr_byte(8'h05, -1, a1);
        wr_byte(8'h5A, 3, a2);
        stop_c();
        check_val("t6_ack_data", a2, 1);
        check_val("t6_nwr", wq_a.size(), 1);
        check_val("t6_wr_addr", wq_a[0], 5);
        check_val("t6_wr_data", wq_d[0], 8'h5A);
        check_val("t6_ptr", ptr, 6);

        // Reset while the target drives a read bit
        clr_mon();
        start_c();
        wr_byte(8'h84, -1, a0);
        wr_byte(8'h01, -1, a1);
        start_c();
        wr_byte(8'h85, -1, a2);
        repeat (Q) @(negedge clk);
        check_val("t7_oe_pre", sda_oe, 1);
        check_val("t7_busy_pre", busy, 1);
        #2 rst = 1'b1;
        #1;
        check_val("t7_rst_sda_oe", sda_oe, 0);
        check_val("t7_rst_busy", busy, 0);
        check_val("t7_rst_ptr", ptr, 0);
        check_val("t7_rst_wr_addr", wr_addr, 0);
        check_val("t7_rst_wr_data", wr_data, 0);
        check_val("t7_rst_rd_addr", rd_addr, 0);
        repeat (2) @(negedge clk);
        scl_i = 1'b1;
        sda_drv = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Recovery after reset
        clr_mon();
        start_c();
        wr_byte(8'h84, -1, a0);
        wr_byte(8'h00, -1, a1);
        wr_byte(8'h77, -1, a2);
        stop_c();
        check_val("t8_nwr", wq_a.size(), 1);
        check_val("t8_wr_addr", wq_a[0], 0);
        check_val("t8_wr_data", wq_d[0], 8'h77);
        check_val("t8_ptr", ptr, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
